// File: rtl/stitch_pkg.sv
// -----------------------------------------------------------------------------
// stitch_pkg
// Shared types and helpers for the Stitch cluster sequencer arbiter.
//   arb_state_e    : arbiter FSM states (IDLE, HOLD, LOCKED)
//   acc_addr_e     : accelerator destination address carried with a request
//   FrepMaxInstLsb : LSB of the FREP/IREP max_inst field inside the opcode
//   is_frep()      : true for FREP_O, FREP_I and IREP instructions
// -----------------------------------------------------------------------------
package stitch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    FP_SS  = 2'd0,
    DMA_SS = 2'd1,
    INT_SS = 2'd2,
    RVV_SS = 2'd3
  } acc_addr_e;

  localparam int unsigned FrepMaxInstLsb = 20;

  // FREP_O (bit 7 set) and FREP_I (bit 7 clear) share the custom-0 opcode,
  // so the 7-bit opcode alone identifies both; IREP has its own opcode.
  localparam logic [6:0] OpcodeFrep = 7'b0001011;
  localparam logic [6:0] OpcodeIrep = 7'b0111111;

  function automatic logic is_frep(input logic [31:0] op);
    return (op[6:0] == OpcodeFrep) || (op[6:0] == OpcodeIrep);
  endfunction

endpackage

// File: rtl/stitch_rr_pick.sv
// -----------------------------------------------------------------------------
// stitch_rr_pick
// Combinational cyclic priority picker: returns the first asserted valid bit at
// or after ptr_i, wrapping from NumReq-1 back to 0.
//   valid_i [NumReq]  : request valid vector
//   ptr_i   [SrcBits] : index with highest priority this cycle
//   idx_o   [SrcBits] : picked index (equals ptr_i when nothing is valid)
//   found_o           : at least one request is valid
// -----------------------------------------------------------------------------
module stitch_rr_pick #(
  parameter  int unsigned NumReq  = 2,
  localparam int unsigned SrcBits = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  valid_i,
  input  logic [SrcBits-1:0] ptr_i,
  output logic [SrcBits-1:0] idx_o,
  output logic               found_o
);

  logic [SrcBits-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    idx_o   = ptr_i;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = SrcBits'((32'(ptr_i) + i) % NumReq);
      if (!found_o && valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/stitch_seq_arbiter.sv
// -----------------------------------------------------------------------------
// stitch_seq_arbiter
// Shares one stitch_sequencer offload port between NumReq requesters. Grants
// round-robin per instruction, holds the selection while the output stalls,
// and locks onto a requester for the whole body of an FREP/IREP loop so loop
// bodies are never interleaved with another requester's instructions.
// Zero-latency: the output is a combinational mux of the selected input.
//
// Ports
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   inp_q*_i [NumReq]       : per-requester request payload and valid
//   inp_qready_o [NumReq]   : per-requester ready (one-hot or zero)
//   oup_q*_o, oup_qvalid_o  : selected request towards the sequencer
//   oup_qready_i            : sequencer ready
//   oup_src_o               : index of the selected requester
//   busy_o                  : arbiter is in HOLD or LOCKED
//   perf_grant_cnt_o        : (STITCH_SEQ_ARB_PERF_EN) transfers per requester
//   perf_lock_stall_o       : (STITCH_SEQ_ARB_PERF_EN) cycles a non-holder is
//                             valid while LOCKED
//
// Optional feature macro: STITCH_SEQ_ARB_PERF_EN (saturating perf counters).
// -----------------------------------------------------------------------------
module stitch_seq_arbiter
  import stitch_pkg::*;
#(
  parameter  int unsigned NumReq      = 2,
  parameter  int unsigned AddrWidth   = 32,
  parameter  int unsigned DataWidth   = 64,
  parameter  int unsigned MaxInstBits = 4,
  localparam int unsigned SrcBits     = $clog2(NumReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  acc_addr_e [NumReq-1:0]              inp_qaddr_i,
  input  logic      [NumReq-1:0][4:0]         inp_qid_i,
  input  logic      [NumReq-1:0][31:0]        inp_qdata_op_i,
  input  logic      [NumReq-1:0][DataWidth-1:0] inp_qdata_arga_i,
  input  logic      [NumReq-1:0][DataWidth-1:0] inp_qdata_argb_i,
  input  logic      [NumReq-1:0][AddrWidth-1:0] inp_qdata_argc_i,
  input  logic      [NumReq-1:0]              inp_qvalid_i,
  output logic      [NumReq-1:0]              inp_qready_o,
  output acc_addr_e                           oup_qaddr_o,
  output logic      [4:0]                     oup_qid_o,
  output logic      [31:0]                    oup_qdata_op_o,
  output logic      [DataWidth-1:0]           oup_qdata_arga_o,
  output logic      [DataWidth-1:0]           oup_qdata_argb_o,
  output logic      [AddrWidth-1:0]           oup_qdata_argc_o,
  output logic      [SrcBits-1:0]             oup_src_o,
  output logic                                oup_qvalid_o,
  input  logic                                oup_qready_i,
`ifdef STITCH_SEQ_ARB_PERF_EN
  output logic      [NumReq-1:0][31:0]        perf_grant_cnt_o,
  output logic      [31:0]                    perf_lock_stall_o,
`endif
  output logic                                busy_o
);

  arb_state_e           state_q;
  logic [SrcBits-1:0]   rr_ptr_q;
  logic [SrcBits-1:0]   sel_q;
  logic [MaxInstBits:0] body_cnt_q;

  logic [SrcBits-1:0]   pick_idx;
  logic                 pick_found;
  logic [SrcBits-1:0]   sel;
  logic                 sel_valid;
  logic                 xfer;
  logic                 stall;
  logic [31:0]          sel_op;
  logic [MaxInstBits:0] body_load;

  function automatic logic [SrcBits-1:0] wrap_inc(input logic [SrcBits-1:0] idx);
    return (idx == SrcBits'(NumReq - 1)) ? '0 : idx + 1'b1;
  endfunction

  stitch_rr_pick #(
    .NumReq (NumReq)
  ) i_rr_pick (
    .valid_i (inp_qvalid_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Only IDLE arbitrates; HOLD and LOCKED keep the registered selection.
  assign sel       = (state_q == IDLE) ? pick_idx : sel_q;
  // Gating with rst_ni keeps the handshake quiet while reset is asserted,
  // even though the mux itself is combinational.
  assign sel_valid = rst_ni & inp_qvalid_i[sel];
  assign xfer      = sel_valid & oup_qready_i;
  assign stall     = sel_valid & ~oup_qready_i;
  assign sel_op    = inp_qdata_op_i[sel];
  // Loop count includes the max_inst+1 body instructions; one extra bit so
  // the all-ones field cannot overflow.
  assign body_load = {1'b0, sel_op[FrepMaxInstLsb +: MaxInstBits]} + (MaxInstBits+1)'(1);

  assign oup_qvalid_o     = sel_valid;
  assign oup_src_o        = sel;
  assign oup_qaddr_o      = inp_qaddr_i[sel];
  assign oup_qid_o        = inp_qid_i[sel];
  assign oup_qdata_op_o   = sel_op;
  assign oup_qdata_arga_o = inp_qdata_arga_i[sel];
  assign oup_qdata_argb_o = inp_qdata_argb_i[sel];
  assign oup_qdata_argc_o = inp_qdata_argc_i[sel];
  assign busy_o           = (state_q != IDLE);

  always_comb begin
    inp_qready_o = '0;
    if (rst_ni) inp_qready_o[sel] = oup_qready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      body_cnt_q <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples values from before the clock edge.
      unique case (state_q)
        IDLE, HOLD: begin
          if (xfer) begin
            rr_ptr_q <= wrap_inc(sel);
            if (is_frep(sel_op)) begin
              body_cnt_q <= body_load;
              sel_q      <= sel;
              state_q    <= LOCKED;
            end else begin
              state_q <= IDLE;
            end
          end else if (stall) begin
            sel_q   <= sel;
            state_q <= HOLD;
          end
        end
        LOCKED: begin
          // Any instruction from the holder, including a nested FREP or a
          // sequencer pass-through op, counts as one body instruction.
          if (xfer) begin
            body_cnt_q <= body_cnt_q - 1'b1;
            if (body_cnt_q == (MaxInstBits+1)'(1)) begin
              state_q  <= IDLE;
              rr_ptr_q <= wrap_inc(sel_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STITCH_SEQ_ARB_PERF_EN
  logic [NumReq-1:0] holder_mask;
  logic              lock_stall;

  always_comb begin
    holder_mask        = '0;
    holder_mask[sel_q] = 1'b1;
  end

  assign lock_stall = (state_q == LOCKED) && |(inp_qvalid_i & ~holder_mask);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_grant_cnt_o  <= '0;
      perf_lock_stall_o <= '0;
    end else begin
      if (xfer && (perf_grant_cnt_o[sel] != '1))
        perf_grant_cnt_o[sel] <= perf_grant_cnt_o[sel] + 32'd1;
      if (lock_stall && (perf_lock_stall_o != '1))
        perf_lock_stall_o <= perf_lock_stall_o + 32'd1;
    end
  end
`endif

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(inp_qready_o));

  a_locked_cnt_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED) |-> (body_cnt_q != '0));

  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (oup_qvalid_o && !oup_qready_i) |=>
      (oup_qvalid_o && $stable(oup_src_o) && $stable(oup_qdata_op_o) &&
       $stable(oup_qdata_arga_o) && $stable(oup_qdata_argb_o) &&
       $stable(oup_qdata_argc_o)));

endmodule

// File: tb/tb_stitch_seq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stitch_seq_arbiter
// Self-checking bench for stitch_seq_arbiter with three requesters. Each
// requester is a queue of pending instructions; a behavioural model tracks
// who owns the port (round-robin pointer, stalled owner, loop owner with a
// remaining instruction count) and is compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_stitch_seq_arbiter;
  import stitch_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MB = 4;
  localparam int SB = $clog2(N);

  localparam logic [31:0] OpFadd  = 32'h0200_0053;
  localparam logic [31:0] OpFmadd = 32'h0200_0043;

  logic                    clk_i;
  logic                    rst_ni;
  acc_addr_e [N-1:0]       inp_qaddr_i;
  logic [N-1:0][4:0]       inp_qid_i;
  logic [N-1:0][31:0]      inp_qdata_op_i;
  logic [N-1:0][DW-1:0]    inp_qdata_arga_i;
  logic [N-1:0][DW-1:0]    inp_qdata_argb_i;
  logic [N-1:0][AW-1:0]    inp_qdata_argc_i;
  logic [N-1:0]            inp_qvalid_i;
  logic [N-1:0]            inp_qready_o;
  acc_addr_e               oup_qaddr_o;
  logic [4:0]              oup_qid_o;
  logic [31:0]             oup_qdata_op_o;
  logic [DW-1:0]           oup_qdata_arga_o;
  logic [DW-1:0]           oup_qdata_argb_o;
  logic [AW-1:0]           oup_qdata_argc_o;
  logic [SB-1:0]           oup_src_o;
  logic                    oup_qvalid_o;
  logic                    oup_qready_i;
  logic                    busy_o;

  stitch_seq_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxInstBits(MB)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .inp_qaddr_i      (inp_qaddr_i),
    .inp_qid_i        (inp_qid_i),
    .inp_qdata_op_i   (inp_qdata_op_i),
    .inp_qdata_arga_i (inp_qdata_arga_i),
    .inp_qdata_argb_i (inp_qdata_argb_i),
    .inp_qdata_argc_i (inp_qdata_argc_i),
    .inp_qvalid_i     (inp_qvalid_i),
    .inp_qready_o     (inp_qready_o),
    .oup_qaddr_o      (oup_qaddr_o),
    .oup_qid_o        (oup_qid_o),
    .oup_qdata_op_o   (oup_qdata_op_o),
    .oup_qdata_arga_o (oup_qdata_arga_o),
    .oup_qdata_argb_o (oup_qdata_argb_o),
    .oup_qdata_argc_o (oup_qdata_argc_o),
    .oup_src_o        (oup_src_o),
    .oup_qvalid_o     (oup_qvalid_o),
    .oup_qready_i     (oup_qready_i),
    .busy_o           (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] op;
    logic [63:0] tag;
  } item_t;

  typedef struct {
    logic [N-1:0] v;
    logic         r;
    int           src;
    logic         ov;
    logic [N-1:0] rdy;
    logic         busy;
  } vec_t;

  item_t        req_q [N][$];
  logic [N-1:0] en;
  logic [63:0]  tag_ctr;
  int           tests;
  int           fails;

  // Reference model of port ownership.
  int m_ptr;    // requester with top priority for the next grant
  int m_hold;   // requester holding a stalled grant, -1 if none
  int m_owner;  // requester owning a loop body
  int m_rem;    // loop-body instructions still to forward, 0 if unlocked

  // DUT observations captured at the last negedge.
  int           snap_src;
  logic         snap_valid;
  logic [N-1:0] snap_ready;
  logic         snap_busy;
  logic [N-1:0] snap_pend;
  int           grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] frep_op(input int max_inst);
    return (32'(max_inst) << 20) | 32'h0000_008B;
  endfunction

  function automatic logic ref_is_rep(input logic [31:0] op);
    return (op[6:0] == 7'h0B) || (op[6:0] == 7'h3F);
  endfunction

  task automatic push(input int r, input logic [31:0] op);
    item_t it;
    it.op   = op;
    it.tag  = tag_ctr;
    tag_ctr = tag_ctr + 64'd1;
    req_q[r].push_back(it);
  endtask

  function automatic int model_sel();
    if (m_rem > 0) return m_owner;
    if (m_hold >= 0) return m_hold;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr + i) % N;
      if (inp_qvalid_i[j]) return j;
    end
    return m_ptr;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_hold  = -1;
    m_owner = 0;
    m_rem   = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      inp_qaddr_i[i] = acc_addr_e'(2'(i));
      inp_qid_i[i]   = 5'(i);
      if (req_q[i].size() > 0) begin
        inp_qvalid_i[i]     = en[i];
        inp_qdata_op_i[i]   = req_q[i][0].op;
        inp_qdata_arga_i[i] = req_q[i][0].tag;
        inp_qdata_argb_i[i] = ~req_q[i][0].tag;
        inp_qdata_argc_i[i] = req_q[i][0].tag[31:0];
      end else begin
        inp_qvalid_i[i]     = 1'b0;
        inp_qdata_op_i[i]   = '0;
        inp_qdata_arga_i[i] = '0;
        inp_qdata_argb_i[i] = '0;
        inp_qdata_argc_i[i] = '0;
      end
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance model and queues.
  task automatic tick(input logic rdy);
    int           es;
    logic         ev;
    logic [N-1:0] er;
    logic [N-1:0] taken;
    logic [31:0]  eop;
    oup_qready_i = rdy;
    drive_inputs();
    @(negedge clk_i);
    es     = model_sel();
    ev     = inp_qvalid_i[es];
    er     = '0;
    er[es] = rdy;
    eop    = inp_qdata_op_i[es];
    check("valid", 64'(oup_qvalid_o), 64'(ev));
    check("src",   64'(oup_src_o),    64'(es));
    check("ready", 64'(inp_qready_o), 64'(er));
    check("busy",  64'(busy_o),       64'((m_rem > 0) || (m_hold >= 0)));
    if (ev) begin
      check("op",   64'(oup_qdata_op_o), 64'(req_q[es][0].op));
      check("arga", oup_qdata_arga_o,    req_q[es][0].tag);
      check("argc", 64'(oup_qdata_argc_o), 64'(req_q[es][0].tag[31:0]));
      check("id",   64'(oup_qid_o),      64'(es));
    end
    snap_src   = int'(oup_src_o);
    snap_valid = oup_qvalid_o;
    snap_ready = inp_qready_o;
    snap_busy  = busy_o;
    snap_pend  = inp_qvalid_i & ~inp_qready_o;
    taken      = inp_qvalid_i & inp_qready_o;
    @(posedge clk_i);
    if (ev && rdy) begin
      grant_log.push_back(es);
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_ptr = (m_owner + 1) % N;
      end else begin
        m_ptr  = (es + 1) % N;
        m_hold = -1;
        if (ref_is_rep(eop)) begin
          m_owner = es;
          m_rem   = int'(eop[20 +: MB]) + 1;
        end
      end
    end else if (ev && m_rem == 0) begin
      m_hold = es;
    end
    for (int i = 0; i < N; i++)
      if (taken[i]) void'(req_q[i].pop_front());
    #1;
  endtask

  // Reset with live requests on the inputs; upstream queues are flushed too.
  task automatic do_reset(input string name);
    oup_qready_i = 1'b1;
    drive_inputs();
    rst_ni = 1'b0;
    #2;
    check({name, "_busy"},  64'(busy_o),       64'(0));
    check({name, "_ready"}, 64'(inp_qready_o), 64'(0));
    check({name, "_valid"}, 64'(oup_qvalid_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) req_q[i].delete();
    model_reset();
    snap_pend = '0;
    grant_log.delete();
  endtask

  function automatic int leading(input int who);
    int n;
    n = 0;
    foreach (grant_log[k]) begin
      if (grant_log[k] != who) return n;
      n++;
    end
    return n;
  endfunction

  vec_t tbl [13];

  initial begin
    tests   = 0;
    fails   = 0;
    tag_ctr = 64'h100;
    en      = '0;
    model_reset();
    snap_pend = '0;
    rst_ni    = 1'b0;
    oup_qready_i = 1'b1;
    push(0, OpFadd);
    push(1, OpFadd);
    en = '1;
    drive_inputs();
    #12;
    check("por_busy",  64'(busy_o),       64'(0));
    check("por_ready", 64'(inp_qready_o), 64'(0));
    check("por_valid", 64'(oup_qvalid_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) req_q[i].delete();

    // Plain round robin, stall stability, pointer wrap.
    tbl[0]  = '{3'b011, 1'b1, 0, 1'b1, 3'b001, 1'b0};
    tbl[1]  = '{3'b011, 1'b1, 1, 1'b1, 3'b010, 1'b0};
    tbl[2]  = '{3'b011, 1'b1, 0, 1'b1, 3'b001, 1'b0};
    tbl[3]  = '{3'b011, 1'b1, 1, 1'b1, 3'b010, 1'b0};
    tbl[4]  = '{3'b001, 1'b0, 0, 1'b1, 3'b000, 1'b0};
    tbl[5]  = '{3'b001, 1'b0, 0, 1'b1, 3'b000, 1'b1};
    tbl[6]  = '{3'b011, 1'b0, 0, 1'b1, 3'b000, 1'b1};
    tbl[7]  = '{3'b011, 1'b1, 0, 1'b1, 3'b001, 1'b1};
    tbl[8]  = '{3'b010, 1'b1, 1, 1'b1, 3'b010, 1'b0};
    tbl[9]  = '{3'b000, 1'b1, 2, 1'b0, 3'b100, 1'b0};
    tbl[10] = '{3'b001, 1'b1, 0, 1'b1, 3'b001, 1'b0};
    tbl[11] = '{3'b101, 1'b1, 2, 1'b1, 3'b100, 1'b0};
    tbl[12] = '{3'b101, 1'b1, 0, 1'b1, 3'b001, 1'b0};
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 10; k++) push(i, OpFadd);
    for (int r = 0; r < 13; r++) begin
      en = tbl[r].v;
      tick(tbl[r].r);
      check($sformatf("tbl%0d_valid", r), 64'(snap_valid), 64'(tbl[r].ov));
      check($sformatf("tbl%0d_src", r),   64'(snap_src),   64'(tbl[r].src));
      check($sformatf("tbl%0d_ready", r), 64'(snap_ready), 64'(tbl[r].rdy));
      check($sformatf("tbl%0d_busy", r),  64'(snap_busy),  64'(tbl[r].busy));
    end

    // Lock: FREP max_inst=2 plus three body ops, req1 competing throughout.
    do_reset("rst_a");
    push(0, frep_op(2));
    for (int k = 0; k < 3; k++) push(0, OpFmadd);
    for (int k = 0; k < 8; k++) push(1, OpFadd);
    en = 3'b011;
    for (int c = 0; c < 6; c++) tick(1'b1);
    check("lock_run",  64'(leading(0)),  64'(4));
    check("lock_next", 64'(grant_log[4]), 64'(1));

    // Lock with a five-cycle idle gap from the holder.
    do_reset("rst_b");
    push(0, frep_op(1));
    push(0, OpFadd);
    push(0, OpFadd);
    for (int k = 0; k < 8; k++) push(1, OpFadd);
    en = 3'b011;
    tick(1'b1);
    tick(1'b1);
    en = 3'b010;
    for (int c = 0; c < 5; c++) begin
      tick(1'b1);
      check("gap_ready1", 64'(snap_ready[1]), 64'(0));
      check("gap_busy",   64'(snap_busy),     64'(1));
    end
    en = 3'b011;
    tick(1'b1);
    tick(1'b1);
    check("gap_run",  64'(leading(0)), 64'(3));
    check("gap_next", 64'(grant_log.size() > 3 ? grant_log[3] : -1), 64'(1));

    // Maximum loop length: max_inst=15 gives 16 body instructions.
    do_reset("rst_c");
    push(0, frep_op(15));
    for (int k = 0; k < 17; k++) push(0, OpFadd);
    for (int k = 0; k < 4; k++) push(1, OpFadd);
    en = 3'b011;
    for (int c = 0; c < 19; c++) tick(1'b1);
    check("max_run",  64'(leading(0)), 64'(17));
    check("max_next", 64'(grant_log.size() > 17 ? grant_log[17] : -1), 64'(1));

    // Reset in the middle of a loop body.
    do_reset("rst_d");
    push(0, frep_op(2));
    for (int k = 0; k < 3; k++) push(0, OpFmadd);
    for (int k = 0; k < 4; k++) push(1, OpFadd);
    en = 3'b011;
    tick(1'b1);
    tick(1'b1);
    check("midlock_busy", 64'(busy_o), 64'(1));
    do_reset("rst_mid");
    push(0, OpFadd);
    push(1, OpFadd);
    en = 3'b011;
    tick(1'b1);
    check("post_rst_src", 64'(snap_src), 64'(0));

    // Randomized traffic against the model.
    do_reset("rst_r");
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset("rst_r2");
      for (int i = 0; i < N; i++) begin
        if (req_q[i].size() < 2 && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 9))
            0:       push(i, frep_op(int'($urandom_range(0, 3))));
            1:       push(i, (32'($urandom_range(0, 3)) << 20) | 32'h0000_003F);
            2:       push(i, (32'($urandom_range(0, 3)) << 20) | 32'h0000_000B);
            3, 4:    push(i, OpFmadd);
            default: push(i, OpFadd);
          endcase
        end
        if (!snap_pend[i]) en[i] = ($urandom_range(0, 3) != 0);
      end
      tick(logic'($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stitch_seq_arbiter.md
Name: stitch_seq_arbiter

Overview:
- Shares one stitch_sequencer offload port between NumReq requesters (integer cores or offload sources) in a Stitch cluster.
- Round-robin arbitration per instruction; never interleaves a requester's FREP/IREP loop body with another requester's instructions.
- Output feeds the sequencer inp_q* port directly; responses are routed by the consumer using oup_src_o.

Parameters:
- NumReq, 2, number of requesters (≥2).
- AddrWidth, 32, argc width.
- DataWidth, 64, arga/argb width.
- MaxInstBits, 4, width of the FREP max_inst field (op[20 +: MaxInstBits]); equals the sequencer's DepthBits.
- Derived, do not override: SrcBits = $clog2(NumReq).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- inp_qaddr_i  in  NumReq x acc_addr_e  per-requester destination
- inp_qid_i  in  NumReq x 5  per-requester id
- inp_qdata_op_i  in  NumReq x 32  RISC-V instruction
- inp_qdata_arga_i / inp_qdata_argb_i  in  NumReq x DataWidth  operands
- inp_qdata_argc_i  in  NumReq x AddrWidth  operand
- inp_qvalid_i  in  NumReq  request valid
- inp_qready_o  out  NumReq  request ready (one-hot or zero)
- oup_qaddr_o, oup_qid_o, oup_qdata_op_o, oup_qdata_arga_o, oup_qdata_argb_o, oup_qdata_argc_o  out  matching widths  selected request
- oup_src_o  out  SrcBits  index of the granted requester
- oup_qvalid_o  out  1
- oup_qready_i  in  1
- busy_o  out  1  high while in LOCKED or HOLD

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (rst_ni).
- Reset values: state=IDLE, rr_ptr=0, body_cnt=0, sel_q=0. Outputs: oup_qvalid_o=0, inp_qready_o=0, busy_o=0.
- Latency: 0. The output is a combinational mux of the selected input; there is no buffering.
- Handshake on the output:
  - oup_qvalid_o = inp_qvalid_i[sel].
  - inp_qready_o[sel] = oup_qready_i; all other readys are 0.
  - A transfer occurs on oup_qvalid_o & oup_qready_i.
- Selection stability: if the output is valid and not ready, sel is held the next cycle (state HOLD). It is never re-arbitrated until the transfer completes, even if a higher-priority requester rises.
- States:
  - IDLE: sel = first valid requester at or after rr_ptr, cyclically. On transfer:
    - rr_ptr <= sel+1, modulo NumReq (wraps NumReq-1 -> 0).
    - If the transferred op is FREP_O, FREP_I or IREP: body_cnt <= op[20 +: MaxInstBits] + 1 (MaxInstBits+1 bits wide, no overflow); sel_q <= sel; go to LOCKED.
    - If valid and not ready: sel_q <= sel; go to HOLD.
  - HOLD: sel = sel_q. On transfer, apply the same FREP check as IDLE, then go to IDLE or LOCKED.
  - LOCKED: sel = sel_q only; other requesters get ready=0 regardless of their valid.
    - Each transfer decrements body_cnt. When body_cnt==1 and a transfer occurs, go to IDLE with rr_ptr <= sel_q+1.
    - Holder idles (valid=0): stay LOCKED with no timeout.
    - Holder sends another FREP while locked: it is forwarded and counted as a body instruction. No reload; nesting is illegal software.
- The direct-path instructions the sequencer passes through (CSR, FMV etc.) are counted like any other instruction from the holder.
- The rr_ptr update uses the granted index, not the pointer value (grant-based fairness).
- Reset mid-lock: immediately returns to IDLE and discards body_cnt. The upstream queues must also be reset.
- Assertions: inp_qready_o is onehot0. In LOCKED, body_cnt != 0. Op, operands and valid of the selected requester are stable while valid & ~ready.

Optional Feature:
- Macro: STITCH_SEQ_ARB_PERF_EN.
- Defined: adds output perf_grant_cnt_o (NumReq x 32), counting transfers per requester, and perf_lock_stall_o (32), counting cycles where a non-holder is valid while LOCKED. Counters saturate at all-ones and reset to 0.
- Undefined: these ports and their registers are absent; the behaviour is otherwise identical.

Decomposition:
- Shared package stitch_pkg holds:
  - arb_state_e {IDLE, HOLD, LOCKED};
  - function is_frep(op), matching riscv_instr::FREP_O/FREP_I/IREP;
  - constant FrepMaxInstLsb = 20.
- One sub-module, stitch_rr_pick: combinational cyclic priority picker (valid vector + pointer -> index + found). Everything else stays in the top.

Test Plan:
- Plain RR: NumReq=2, both valid continuously with FADD.D, ready=1 -> oup_src_o alternates 0,1,0,1.
- Stall stability: req0 valid, ready=0 for 3 cycles, req1 raises valid in cycle 2 -> oup_src_o stays 0; req0 transfers in cycle 4, then req1 is granted.
- Lock: req0 sends FREP_O with max_inst=2, followed by 3 FMADD.D; req1 valid throughout -> exactly 4 consecutive transfers from req0, then req1 is granted.
- Lock idle gap: req0 FREP max_inst=1; req0 drops valid for 5 cycles between body instructions -> req1 ready stays 0 throughout; the lock releases after the 2nd body transfer.
- Wrap and boundary: NumReq=3, rr_ptr=2, only req0 valid -> req0 granted, rr_ptr becomes 1. FREP with max_inst=15 (MaxInstBits=4) -> body_cnt=16 and exactly 16 body transfers are counted.
- Reset mid-lock: assert rst_ni low after 1 of 3 body instructions -> busy_o=0 and all readys 0 during reset; the first grant after reset follows rr_ptr=0.
